fifo_sync_flags: RTL and testbench
==================================

FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR, default 3, address width; depth is 2**ADDR.
REQ-003 SHALL have parameter DEPTH, default 8, always equal to 2**ADDR.
REQ-004 SHALL have parameter AFULL_TH, default 6, almost-full threshold (1..DEPTH-1).
REQ-005 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold (1..DEPTH-1).
REQ-006 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-007 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port winc, input, 1, write request.
REQ-010 SHALL have port wdata, input, WIDTH, write data.
REQ-011 SHALL have port rinc, input, 1, read request.
REQ-012 SHALL have port clr_err, input, 1, synchronous clear of sticky error flags.
REQ-013 SHALL have port rdata, output, WIDTH, read data.
REQ-014 SHALL have ports wfull, rempty, afull, aempty, outputs, 1 each, status flags.
REQ-015 SHALL have port count, output, ADDR+1, current occupancy.
REQ-016 SHALL have ports ovf, udf, outputs, 1 each, sticky overflow/underflow.

Function
REQ-017 SHALL accept a write when winc=1 and wfull=0; wdata is stored at write pointer, pointer increments mod DEPTH.
REQ-018 SHALL accept a read when rinc=1 and rempty=0; read pointer increments mod DEPTH.
REQ-019 SHALL ignore winc while wfull=1, even with a simultaneous accepted read (no pass-through).
REQ-020 SHALL ignore rinc while rempty=1, even with a simultaneous write (no bypass).
REQ-021 SHALL update count registered: +1 write-only, -1 read-only, unchanged on both or neither accepted.
REQ-022 SHALL decode flags from registered count: wfull=(count==DEPTH), rempty=(count==0), afull=(count>=AFULL_TH), aempty=(count<=AEMPTY_TH).
REQ-023 SHALL therefore reflect an accepted operation in count and all flags on the clock edge after the request cycle.
REQ-024 SHALL, with FWFT=0, register rdata with the head word on the edge that accepts a read (1-cycle latency); rdata holds otherwise.
REQ-025 SHALL, with FWFT=1, drive rdata combinationally with the head word whenever rempty=0; rinc consumes it; rdata is don't-care when rempty=1.
REQ-026 SHALL set ovf on the edge after a cycle with winc=1 and wfull=1; set udf likewise for rinc=1 and rempty=1.
REQ-027 SHALL clear ovf and udf on a cycle with clr_err=1; a simultaneous set condition takes priority over clear.
REQ-028 SHALL not alter stored data, pointers or count on rejected requests.
REQ-029 SHALL wrap both pointers from DEPTH-1 to 0 with no data loss or flag glitch.
REQ-030 SHALL use ADDR+1-bit count so DEPTH is representable without ambiguity between full and empty.

Reset
REQ-031 SHALL on rst_n=0 immediately clear pointers, count, ovf, udf, and (FWFT=0) rdata to 0, independent of clk.
REQ-032 SHALL present rempty=1, aempty=1, wfull=0, afull=0 while and after reset.
REQ-033 SHALL not reset storage array contents; reset mid-operation discards all stored words.
REQ-034 SHALL accept requests on the first rising edge after rst_n deasserts.

Verification (WIDTH=8, ADDR=3, AFULL_TH=6, AEMPTY_TH=2)
REQ-035 SHALL cover fill: 8 writes 0x01..0x08, no reads -> count 0..8, afull at count 6, wfull at count 8, aempty deasserts at count 3.
REQ-036 SHALL cover overflow: 9th write 0xFF while full -> ovf=1, count stays 8, later reads return 0x01..0x08 (0xFF never read).
REQ-037 SHALL cover drain, FWFT=0: 8 reads -> rdata 0x01..0x08 each one cycle after rinc, rempty=1 after 8th; 9th read sets udf, rdata holds 0x08.
REQ-038 SHALL cover simultaneous: at count 4, winc+rinc for 10 cycles -> count stays 4, pointers wrap, output order preserved.
REQ-039 SHALL cover FWFT=1: single write 0x5A -> rdata=0x5A the cycle rempty falls, no rinc needed; rinc -> rempty=1.
REQ-040 SHALL cover reset mid-operation: rst_n=0 at count 5 with ovf=1 -> count 0, rempty=1, ovf=0 asynchronously; clr_err with winc at full -> ovf stays 1.

Source files
------------

// File: rtl/fifo_sync_flags_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_flags_if
// Brief    : Handshake, data and status bundle for fifo_sync_flags.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_sync_flags_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3
);
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic             clr_err;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             afull;
    logic             aempty;
    logic [ADDR:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  rdata, wfull, rempty, afull, aempty, count, ovf, udf
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output rdata, wfull, rempty, afull, aempty, count, ovf, udf
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_flags
// Brief    : Single-clock FIFO with occupancy count, threshold flags and
//            sticky overflow/underflow; registered or FWFT read port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
    parameter int WIDTH     = 8,
    parameter int ADDR      = 3,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  wire             clk,
    input  wire             rst_n,
    fifo_sync_flags_if.slave bus
);

    localparam logic [ADDR:0]   c_DEPTH   = DEPTH[ADDR:0];
    localparam logic [ADDR:0]   c_AFULL   = AFULL_TH[ADDR:0];
    localparam logic [ADDR:0]   c_AEMPTY  = AEMPTY_TH[ADDR:0];
    localparam logic [ADDR:0]   c_CNT_ONE = 1;
    localparam logic [ADDR-1:0] c_PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR-1:0]  r_wptr;
    logic [ADDR-1:0]  r_rptr;
    logic [ADDR:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // All flags decode from the registered count, so they are glitch-free.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A full FIFO never passes a write through and an empty one never
    // bypasses a read, even when the opposite side is active.
    assign w_wr_ok = bus.winc & ~w_full;
    assign w_rd_ok = bus.rinc & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set beats clear so an error in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.winc && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end
            if (bus.rinc && w_empty) begin
                r_udf <= 1'b1;
            end else if (bus.clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata = r_mem[r_rptr];
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_ok) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end

            assign bus.rdata = r_rdata;
        end
    endgenerate

    assign bus.wfull  = w_full;
    assign bus.rempty = w_empty;
    assign bus.afull  = (r_count >= c_AFULL);
    assign bus.aempty = (r_count <= c_AEMPTY);
    assign bus.count  = r_count;
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_flags
// Brief    : Directed self-checking bench for fifo_sync_flags, registered
//            read (FWFT=0) and first-word-fall-through (FWFT=1) builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fifo_sync_flags_if #(.WIDTH(8), .ADDR(3)) b0 ();
    fifo_sync_flags_if #(.WIDTH(8), .ADDR(3)) b1 ();

    fifo_sync_flags #(
        .WIDTH(8), .ADDR(3), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)
    ) u_dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    fifo_sync_flags #(
        .WIDTH(8), .ADDR(3), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)
    ) u_dut_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [7:0] d);
        b0.winc  = 1'b1;
        b0.wdata = d;
        tick();
        b0.winc  = 1'b0;
    endtask

    task automatic rd0(input logic [7:0] exp);
        b0.rinc = 1'b1;
        tick();
        b0.rinc = 1'b0;
        check("rd0_data", b0.rdata, exp);
    endtask

    task automatic idle_flags(input string tag);
        check({tag, "_count"},  b0.count,  0);
        check({tag, "_rempty"}, b0.rempty, 1);
        check({tag, "_aempty"}, b0.aempty, 1);
        check({tag, "_wfull"},  b0.wfull,  0);
        check({tag, "_afull"},  b0.afull,  0);
        check({tag, "_ovf"},    b0.ovf,    0);
        check({tag, "_udf"},    b0.udf,    0);
        check({tag, "_rdata"},  b0.rdata,  0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        b0.winc    = 1'b0; b0.rinc = 1'b0; b0.clr_err = 1'b0; b0.wdata = 8'h00;
        b1.winc    = 1'b0; b1.rinc = 1'b0; b1.clr_err = 1'b0; b1.wdata = 8'h00;

        // ---------------- reset state
        #12;
        idle_flags("reset");
        check("reset_fwft_rempty", b1.rempty, 1);
        rst_n = 1'b1;

        // ---------------- fill 0x01..0x08
        for (int i = 0; i < 8; i++) begin
            wr0(8'(i + 1));
            check("fill_count",  b0.count,  i + 1);
            check("fill_afull",  b0.afull,  (i + 1) >= 6);
            check("fill_wfull",  b0.wfull,  (i + 1) == 8);
            check("fill_aempty", b0.aempty, (i + 1) <= 2);
        end

        // ---------------- overflow: 0xFF must never be stored
        wr0(8'hFF);
        check("ovf_set",   b0.ovf,   1);
        check("ovf_count", b0.count, 8);

        // ---------------- drain with 1-cycle registered latency
        for (int i = 0; i < 8; i++) begin
            rd0(8'(i + 1));
            check("drain_count", b0.count, 7 - i);
        end
        check("drain_rempty", b0.rempty, 1);
        rd0(8'h08);
        check("udf_set",   b0.udf,   1);
        check("udf_count", b0.count, 0);

        b0.clr_err = 1'b1;
        tick();
        b0.clr_err = 1'b0;
        check("clr_ovf", b0.ovf, 0);
        check("clr_udf", b0.udf, 0);

        // ---------------- simultaneous at count 4, pointers wrap
        for (int i = 0; i < 4; i++) wr0(8'(8'h10 + i));
        for (int k = 0; k < 10; k++) begin
            b0.winc  = 1'b1;
            b0.wdata = 8'(8'h20 + k);
            b0.rinc  = 1'b1;
            tick();
            check("simul_count", b0.count, 4);
            check("simul_data",  b0.rdata, (k < 4) ? (8'h10 + k) : (8'h20 + k - 4));
        end
        b0.winc = 1'b0;
        b0.rinc = 1'b0;
        for (int i = 0; i < 4; i++) rd0(8'(8'h26 + i));

        // ---------------- no bypass when empty
        b0.winc  = 1'b1;
        b0.wdata = 8'h33;
        b0.rinc  = 1'b1;
        tick();
        b0.winc = 1'b0;
        b0.rinc = 1'b0;
        check("nobyp_count", b0.count, 1);
        check("nobyp_udf",   b0.udf,   1);
        check("nobyp_rdata", b0.rdata, 8'h29);
        b0.clr_err = 1'b1;
        tick();
        b0.clr_err = 1'b0;

        // ---------------- no pass-through when full
        for (int i = 0; i < 7; i++) wr0(8'(8'h34 + i));
        check("full2_wfull", b0.wfull, 1);
        b0.winc  = 1'b1;
        b0.wdata = 8'hEE;
        b0.rinc  = 1'b1;
        tick();
        b0.winc = 1'b0;
        b0.rinc = 1'b0;
        check("nopass_count", b0.count, 7);
        check("nopass_ovf",   b0.ovf,   1);
        check("nopass_rdata", b0.rdata, 8'h33);
        rd0(8'h34);
        rd0(8'h35);
        check("pre_rst_count", b0.count, 5);

        // ---------------- asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        idle_flags("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wr0(8'h77);
        check("post_rst_count", b0.count, 1);
        for (int i = 0; i < 7; i++) wr0(8'(8'h78 + i));
        check("post_rst_full", b0.wfull, 1);

        // set wins over clear in the same cycle
        b0.clr_err = 1'b1;
        b0.winc    = 1'b1;
        b0.wdata   = 8'hAA;
        tick();
        b0.winc = 1'b0;
        check("set_prio_ovf", b0.ovf, 1);
        tick();
        b0.clr_err = 1'b0;
        check("clr_only_ovf", b0.ovf, 0);
        rd0(8'h77);

        // ---------------- FWFT build
        b1.winc  = 1'b1;
        b1.wdata = 8'h5A;
        tick();
        b1.winc = 1'b0;
        check("fwft_rempty", b1.rempty, 0);
        check("fwft_rdata",  b1.rdata,  8'h5A);
        b1.rinc = 1'b1;
        tick();
        b1.rinc = 1'b0;
        check("fwft_empty_after", b1.rempty, 1);
        check("fwft_count",       b1.count,  0);
        b1.winc = 1'b1;
        b1.wdata = 8'hC1;
        tick();
        b1.wdata = 8'hC2;
        tick();
        b1.winc = 1'b0;
        check("fwft_head1", b1.rdata, 8'hC1);
        b1.rinc = 1'b1;
        tick();
        b1.rinc = 1'b0;
        check("fwft_head2", b1.rdata, 8'hC2);
        check("fwft_count2", b1.count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
